// File: rtl/rsqrt_pkg.sv
// rsqrt_pkg
//   Shared definitions for the fast inverse-square-root front end:
//   seed/NaN constants, FP32 field geometry and the operand class enum.
package rsqrt_pkg;

    localparam int DATA_W   = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_LSB  = 23;
    localparam int SIGN_BIT = 31;

    localparam logic [DATA_W-1:0] MAGIC   = 32'h5F3759DF;
    localparam logic [DATA_W-1:0] QNAN    = 32'h7FC00000;
    localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_NEG,
        CLS_NORM
    } op_class_t;

endpackage

// File: rtl/fp32_classify.sv
// fp32_classify
//   Combinational FP32 operand classifier.
//   Ports:
//     x    in   32  IEEE-754 single operand
//     cls  out      operand class (ZERO/INF/NAN/NEG/NORM)
//     expo out  8   biased exponent field
//     man  out  23  mantissa field
module fp32_classify
    import rsqrt_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    output op_class_t         cls,
    output logic [EXP_W-1:0]  expo,
    output logic [MAN_W-1:0]  man
);

    logic sign;

    always_comb begin
        sign = x[SIGN_BIT];
        expo = x[EXP_LSB +: EXP_W];
        man  = x[MAN_W-1:0];
        cls  = CLS_NORM;
        // Priority order matters: denormals flush to ZERO regardless of
        // sign, NaN wins over sign, and negative infinity lands in NEG.
        if (expo == '0) begin
            cls = CLS_ZERO;
        end else if (expo == EXP_MAX && man != '0) begin
            cls = CLS_NAN;
        end else if (sign) begin
            cls = CLS_NEG;
        end else if (expo == EXP_MAX) begin
            cls = CLS_INF;
        end
    end

endmodule

// File: rtl/rsqrt_seed_gen.sv
// rsqrt_seed_gen
//   Front end of the fast inverse-square-root datapath. Produces
//   half = 0.5*x and the magic-constant seed y0 = MAGIC - (x >> 1);
//   special operands are resolved here and flagged as final.
//   Two-stage registered pipeline with full valid/ready backpressure.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     in_valid/in_ready   input handshake, in_data = operand x
//     out_valid/out_ready output handshake
//     out_half            0.5*x for the Newton stage
//     out_seed            y0, or the final result when out_bypass=1
//     out_bypass          out_seed is exact; skip refinement
module rsqrt_seed_gen
    import rsqrt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_half,
    output logic [DATA_W-1:0]   out_seed,
    output logic                out_bypass
);

    function automatic logic [DATA_W-1:0] half_of(input op_class_t c,
                                                  input logic [EXP_W-1:0] e,
                                                  input logic [MAN_W-1:0] m);
        if (c != CLS_NORM)
            return '0;
        // Smallest normal halves into the denormal range: the hidden bit
        // becomes explicit and the mantissa LSB is truncated.
        if (e == 8'd1)
            return {1'b0, 8'h00, 1'b1, m[MAN_W-1:1]};
        return {1'b0, e - 8'd1, m};
    endfunction

    function automatic logic [DATA_W-1:0] seed_of(input op_class_t c,
                                                  input logic [DATA_W-1:0] x);
        case (c)
            CLS_NORM: return MAGIC - {1'b0, x[DATA_W-1:1]};
            CLS_ZERO: return {x[SIGN_BIT], EXP_MAX, {MAN_W{1'b0}}};
            CLS_INF:  return '0;
            default:  return QNAN;
        endcase
    endfunction

    op_class_t          cls_p0;
    logic [EXP_W-1:0]   exp_p0;
    logic [MAN_W-1:0]   man_p0;

    logic [DATA_W-1:0]  x_p1;
    op_class_t          cls_p1;
    logic [EXP_W-1:0]   exp_p1;
    logic [MAN_W-1:0]   man_p1;
    logic               vld_p1;
    logic               vld_p2;
    logic               s1_adv;
    logic               s2_adv;

    fp32_classify u_classify (
        .x    (in_data),
        .cls  (cls_p0),
        .expo (exp_p0),
        .man  (man_p0)
    );

    assign s2_adv    = !vld_p2 || out_ready;
    assign s1_adv    = !vld_p1 || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_p2;

    // ---- S1: capture operand and class ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            x_p1   <= in_data;
            cls_p1 <= cls_p0;
            exp_p1 <= exp_p0;
            man_p1 <= man_p0;
        end
    end

    // ---- S2: compute half/seed, register outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2     <= 1'b0;
            out_half   <= '0;
            out_seed   <= '0;
            out_bypass <= 1'b0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            // Outputs only reload with a real operand so they never show
            // contents of an S1 register that was never written.
            if (vld_p1) begin
                out_half   <= half_of(cls_p1, exp_p1, man_p1);
                out_seed   <= seed_of(cls_p1, x_p1);
                out_bypass <= (cls_p1 != CLS_NORM);
            end
        end
    end

endmodule
